// File: rtl/seg7_scan_driver.sv
// Multi-digit 7-segment driver: sequential binary-to-BCD conversion plus a prescaled digit scan.
// Optional feature: define SEG7_LZ_BLANK_EN to blank leading zeros.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic                  conv_done,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] seg_scan
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  function automatic logic [63:0] max_display();
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < NUM_DIGITS; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_display();

  // Digit code 4'hF marks a dash so overflow frames never look like leading zeros.
  localparam logic [3:0] DASH_CODE = 4'hF;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:      return 7'h3F;
      4'd1:      return 7'h06;
      4'd2:      return 7'h5B;
      4'd3:      return 7'h4F;
      4'd4:      return 7'h66;
      4'd5:      return 7'h6D;
      4'd6:      return 7'h7D;
      4'd7:      return 7'h07;
      4'd8:      return 7'h7F;
      4'd9:      return 7'h6F;
      DASH_CODE: return 7'h40;
      default:   return 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                 state_q, state_d;
  logic [BIN_W-1:0]       shift_q;
  logic [BCD_W-1:0]       bcd_q, bcd_adj;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_pend_q;
  logic [BCD_W-1:0]       disp_q;
  logic                   ovf_q;
  logic                   conv_done_q;
  logic [PRE_W-1:0]       presc_q;
  logic [IDX_W-1:0]       idx_q;
  logic [6:0]             seg_q, seg_d;
  logic [NUM_DIGITS-1:0]  scan_q, scan_d;
  logic [3:0]             cur_code;
  logic                   blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    bin_ready = 1'b0;
    case (state_q)
      IDLE: begin
        bin_ready = 1'b1;
        if (bin_valid) state_d = CONV;
      end
      CONV:    if (cnt_q == CNT_W'(1)) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift-add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
      conv_done_q <= 1'b0;
    end else begin
      conv_done_q <= (state_q == LOAD);
      case (state_q)
        IDLE: begin
          if (bin_valid) begin
            shift_q    <= bin;
            bcd_q      <= '0;
            cnt_q      <= CNT_W'(BIN_W);
            ovf_pend_q <= (64'(bin) > MAX_VAL);
          end
        end
        CONV: begin
          {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
          cnt_q            <= cnt_q - CNT_W'(1);
        end
        LOAD: begin
          disp_q <= ovf_pend_q ? {NUM_DIGITS{DASH_CODE}} : bcd_q;
          ovf_q  <= ovf_pend_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc_q <= presc_q + PRE_W'(1);
    end
  end

  always_comb begin
    cur_code = 4'd0;
    scan_d   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code  = disp_q[4*i +: 4];
        scan_d[i] = 1'b0;
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;
  logic                  run_zero;

  // zero_from[i]: this digit and every digit above it are zero.
  always_comb begin
    zero_from = '0;
    run_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero     = run_zero & (disp_q[4*i +: 4] == 4'd0);
      zero_from[i] = run_zero;
    end
  end

  always_comb begin
    blank = 1'b0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i) && zero_from[i]) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign seg_d = blank ? 7'h00 : decode(cur_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= 7'h00;
      scan_q <= '1;
    end else begin
      seg_q  <= seg_d;
      scan_q <= scan_d;
    end
  end

  assign seg       = seg_q;
  assign seg_scan  = scan_q;
  assign conv_done = conv_done_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: randomized values checked against an arithmetic model
// of conversion, overflow and scan timing; a second instance covers the single-cycle scan case.
module tb_seg7_scan_driver;

  localparam int ND       = 4;
  localparam int BW       = 14;
  localparam int SD       = 4;
  localparam int LATENCY  = BW + 1;
  localparam int MAXV     = 9999;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [BW-1:0] bin = '0;
  logic          bin_valid = 1'b0;
  logic          bin_ready, conv_done, ovf;
  logic [6:0]    seg;
  logic [ND-1:0] seg_scan;

  logic [9:0]    bin3 = '0;
  logic          bin_valid3 = 1'b0;
  logic          bin_ready3, conv_done3, ovf3;
  logic [6:0]    seg3;
  logic [2:0]    seg_scan3;

  seg7_scan_driver #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .bin(bin), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .conv_done(conv_done), .ovf(ovf), .seg(seg), .seg_scan(seg_scan)
  );

  seg7_scan_driver #(.NUM_DIGITS(3), .BIN_W(10), .SCAN_DIV(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bin(bin3), .bin_valid(bin_valid3), .bin_ready(bin_ready3),
    .conv_done(conv_done3), .ovf(ovf3), .seg(seg3), .seg_scan(seg_scan3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int acc;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         last_acc = -1000;
  int         disp_val = 0;
  bit         disp_ovf = 1'b0;
  int         shown_val = 0;
  bit         shown_ovf = 1'b0;
  int         n_compared = 0;
  int         n_mismatched = 0;
  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Rising edges since reset release; the scan position follows from this alone.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input bit ov, input int d);
    int digit;
    if (ov) return 7'h40;
    digit = (val / pow10(d)) % 10;
`ifdef SEG7_LZ_BLANK_EN
    if (d > 0 && val < pow10(d)) return 7'h00;
`endif
    return seg_tbl[digit];
  endfunction

  // Converter is busy for LATENCY cycles starting at the accepting edge.
  function automatic bit model_ready(input int c);
    return !(c >= last_acc && c <= last_acc + LATENCY - 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int v, input bit wait_ready);
    @(negedge clk);
    if (wait_ready) while (!model_ready(cyc)) @(negedge clk);
    bin       = BW'(v);
    bin_valid = 1'b1;
    if (model_ready(cyc)) begin
      sb_q.push_back('{v, cyc + 1});
      last_acc = cyc + 1;
    end
    @(negedge clk);
    bin_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb_q.delete();
    last_acc  = -1000;
    disp_val  = 0;
    disp_ovf  = 1'b0;
    shown_val = 0;
    shown_ovf = 1'b0;
    #1;
    checkOutput("async_rst_seg", 32'(seg), 32'h00);
    checkOutput("async_rst_scan", 32'(seg_scan), 32'hF);
    checkOutput("async_rst_ready", 32'(bin_ready), 32'h1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: scan/segment/ready every cycle, scoreboard pop whenever conv_done is presented.
  always @(negedge clk) begin
    int   d, d3;
    exp_t item;
    if (!rst_n || cyc == 0) begin
      checkOutput("rst_seg", 32'(seg), 32'h00);
      checkOutput("rst_scan", 32'(seg_scan), 32'hF);
      checkOutput("rst_ready", 32'(bin_ready), 32'h1);
      checkOutput("rst_conv_done", 32'(conv_done), 32'h0);
      checkOutput("rst_ovf", 32'(ovf), 32'h0);
      checkOutput("rst_scan3", 32'(seg_scan3), 32'h7);
    end else begin
      d = ((cyc - 1) / SD) % ND;
      checkOutput("seg_scan", 32'(seg_scan), 32'hF & ~(32'd1 << d));
      checkOutput("seg", 32'(seg), 32'(exp_seg(shown_val, shown_ovf, d)));
      d3 = (cyc - 1) % 3;
      checkOutput("seg_scan3", 32'(seg_scan3), 32'h7 & ~(32'd1 << d3));
      checkOutput("seg3", 32'(seg3), 32'(exp_seg(0, 1'b0, d3)));
      checkOutput("bin_ready", 32'(bin_ready), 32'(model_ready(cyc)));
      if (conv_done) begin
        if (sb_q.size() == 0) begin
          checkOutput("conv_done_unexpected", 32'h1, 32'h0);
        end else begin
          item = sb_q.pop_front();
          checkOutput("latency", 32'(cyc - item.acc), 32'(LATENCY));
          disp_val = item.val;
          disp_ovf = (item.val > MAXV);
        end
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].acc + LATENCY) begin
        checkOutput("conv_done_timeout", 32'h0, 32'h1);
        void'(sb_q.pop_front());
      end
      checkOutput("ovf", 32'(ovf), 32'(disp_ovf));
      shown_val = disp_val;
      shown_ovf = disp_ovf;
    end
  end

  initial begin
    int v, gap, budget;
    #1 rst_n = 1'b0;
    #20;
    @(posedge clk);
    #2 rst_n = 1'b1;

    waitCycles(20);
    applyStimulus(1234, 1'b1);
    waitCycles(40);
    applyStimulus(9999, 1'b1);
    waitCycles(20);
    applyStimulus(10000, 1'b1);
    waitCycles(40);
    applyStimulus(42, 1'b1);
    waitCycles(3);
    applyStimulus(5678, 1'b0);
    waitCycles(40);
    applyStimulus(777, 1'b1);
    waitCycles(6);
    doReset();
    waitCycles(20);
    applyStimulus(5, 1'b1);
    waitCycles(40);
    applyStimulus(0, 1'b1);
    waitCycles(24);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 99);
      else                           v = $urandom_range(0, 16383);
      applyStimulus(v, ($urandom_range(0, 4) != 0));
      gap = $urandom_range(0, 24);
      waitCycles(gap);
    end

    budget = 100;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("drain", 32'(sb_q.size()), 32'h0);
    waitCycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
